systolic_ws_array: RTL and testbench

- Parametrised weight-stationary systolic matrix-vector engine.
- Computes y[c] = sum over r of a[r]*W[r][c] for a stream of activation vectors against a preloaded ROWS x COLS weight tile.
- Successor to the fixed 8x8 array, adding:
  - independent ROWS/COLS and a separate accumulator width;
  - internal input skew and output de-skew;
  - valid/ready handshakes with global backpressure;
  - a load/compute/drain controller.
- Sits between the activation buffer and the accumulator/writeback stage.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/ws_pe.sv | 40 ++++
 rtl/systolic_ws_array.sv | 164 ++++++++++++++++
 tb/tb_systolic_ws_array.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and a width helper for the weight-stationary systolic array.
package systolic_pkg;

  function automatic int clog2(input int unsigned value);
    int result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) result++;
    return result;
  endfunction

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ROWS       = 4;
  localparam int DEFAULT_ACC_WIDTH  = 2 * DEFAULT_DATA_WIDTH + clog2(DEFAULT_ROWS);

  typedef enum logic [1:0] {
    ST_LOAD_W  = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/ws_pe.sv
// Weight-stationary processing element: holds one weight, forwards its activation right and its partial sum down.
module ws_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         w_we,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic signed [ACC_WIDTH-1:0]  sum_in,
  output logic signed [DATA_WIDTH-1:0] act_out,
  output logic signed [ACC_WIDTH-1:0]  sum_out
);

  logic signed [DATA_WIDTH-1:0]   weight;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = act_in * weight;

  // Weight writes only happen during the load phase, so they ignore the pipeline enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) weight <= '0;
    else if (w_we) weight <= w_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_out <= '0;
      sum_out <= '0;
    end else if (en) begin
      act_out <= act_in;
      sum_out <= sum_in + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/systolic_ws_array.sv
// ROWS x COLS weight-stationary matrix-vector engine with input skew, output de-skew,
// a valid/last token pipeline and a load/compute/drain controller.
module systolic_ws_array
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic                       a_last,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [COLS*ACC_WIDTH-1:0]  y_data,
  output logic                       y_last,
  output logic                       busy
);

  localparam int L   = ROWS + COLS;
  localparam int WCW = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(ROWS - 1);

  state_t         state;
  logic [WCW-1:0] w_cnt;
  logic           stall, en, w_fire, a_fire;
  logic [L-1:0]   tok_v, tok_l;

  logic signed [DATA_WIDTH-1:0] row_in [ROWS];
  logic signed [DATA_WIDTH-1:0] act    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  psum   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  col_out[COLS];

  assign stall   = y_valid & ~y_ready;
  assign en      = ~stall;
  assign w_ready = (state == ST_LOAD_W);
  assign a_ready = (state == ST_COMPUTE) & ~stall;
  assign busy    = (state != ST_LOAD_W) | (w_cnt != '0);
  assign w_fire  = w_valid & w_ready;
  assign a_fire  = a_valid & a_ready;
  assign y_valid = tok_v[L-1];
  assign y_last  = tok_l[L-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD_W;
      w_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD_W: begin
          if (w_fire) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= ST_COMPUTE;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: if (a_fire && a_last) state <= ST_DRAIN;
        ST_DRAIN:   if (y_valid && y_ready && y_last) state <= ST_LOAD_W;
        default:    state <= ST_LOAD_W;
      endcase
    end
  end

  // Tokens travel alongside the data wavefront; idle cycles shift in a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_v <= '0;
      tok_l <= '0;
    end else if (en) begin
      tok_v <= {tok_v[L-2:0], a_fire};
      tok_l <= {tok_l[L-2:0], a_fire & a_last};
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DATA_WIDTH-1:0] a_in;
    assign a_in = a_fire ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (r == 0) begin : g_noskew
      assign row_in[r] = a_in;
    end else begin : g_skew
      logic signed [DATA_WIDTH-1:0] sk [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned k = 0; k < r; k++) sk[k] <= '0;
        end else if (en) begin
          sk[0] <= a_in;
          for (int unsigned k = 1; k < r; k++) sk[k] <= sk[k-1];
        end
      end
      assign row_in[r] = sk[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] act_in;
      logic signed [ACC_WIDTH-1:0]  sum_in;

      if (c == 0) begin : g_act_edge
        assign act_in = row_in[r];
      end else begin : g_act_chain
        assign act_in = act[r][c-1];
      end

      if (r == 0) begin : g_sum_top
        assign sum_in = '0;
      end else begin : g_sum_chain
        assign sum_in = psum[r-1][c];
      end

      ws_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .w_we   (w_fire && (w_cnt == WCW'(r))),
        .w_in   (w_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .act_in (act_in),
        .sum_in (sum_in),
        .act_out(act[r][c]),
        .sum_out(psum[r][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    logic signed [ACC_WIDTH-1:0] y_q;

    if (D == 0) begin : g_direct
      assign col_out[c] = psum[ROWS-1][c];
    end else begin : g_dly
      logic signed [ACC_WIDTH-1:0] ds [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned k = 0; k < D; k++) ds[k] <= '0;
        end else if (en) begin
          ds[0] <= psum[ROWS-1][c];
          for (int unsigned k = 1; k < D; k++) ds[k] <= ds[k-1];
        end
      end
      assign col_out[c] = ds[D-1];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) y_q <= '0;
      else if (en) y_q <= col_out[c];
    end

    assign y_data[c*ACC_WIDTH +: ACC_WIDTH] = y_q;
  end

endmodule

// File: tb/tb_systolic_ws_array.sv
// Directed bench for systolic_ws_array: default 4x4 instance plus an 8-bit-accumulator instance for wrap-around.
module tb_systolic_ws_array;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int L  = R + C;

  logic clk = 1'b0;
  logic reset;
  logic w_valid, w_ready, a_valid, a_ready, a_last, y_valid, y_ready, y_last, busy;
  logic [C*DW-1:0] w_data;
  logic [R*DW-1:0] a_data;
  logic [C*AW-1:0] y_data;

  logic w8_valid, w8_ready, a8_valid, a8_ready, a8_last, y8_valid, y8_ready, y8_last, busy8;
  logic [C*DW-1:0] w8_data;
  logic [R*DW-1:0] a8_data;
  logic [C*8-1:0]  y8_data;

  int checks = 0;
  int failures = 0;

  int wmat [R][C];
  int avec [16][R];
  logic [C*AW-1:0] got_y [16];
  logic            got_last [16];
  int got_n, stall_err, stall_cnt, stream_cycles;
  bit timeout, w_noise;

  always #5 clk = ~clk;

  systolic_ws_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .busy(busy)
  );

  systolic_ws_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .w_valid(w8_valid), .w_ready(w8_ready), .w_data(w8_data),
    .a_valid(a8_valid), .a_ready(a8_ready), .a_data(a8_data), .a_last(a8_last),
    .y_valid(y8_valid), .y_ready(y8_ready), .y_data(y8_data), .y_last(y8_last),
    .busy(busy8)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [C*DW-1:0] pack_w_row(input int r);
    logic [C*DW-1:0] v;
    int e;
    for (int c = 0; c < C; c++) begin
      e = wmat[r][c];
      v[c*DW +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  function automatic logic [R*DW-1:0] pack_a(input int i);
    logic [R*DW-1:0] v;
    int e;
    for (int r = 0; r < R; r++) begin
      e = avec[i][r];
      v[r*DW +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  function automatic logic [C*AW-1:0] model_y(input int i);
    logic [C*AW-1:0] v;
    int s;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++) s += avec[i][r] * wmat[r][c];
      v[c*AW +: AW] = s[AW-1:0];
    end
    return v;
  endfunction

  task automatic load_w();
    for (int r = 0; r < R; r++) begin
      w_valid = 1'b1;
      w_data  = pack_w_row(r);
      cyc();
    end
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  // Streams n vectors (a_last on the final one), collecting popped results and stall stability.
  task automatic run_stream(input int n, input bit bp);
    int idx = 0;
    int cn = 0;
    logic [C*AW-1:0] held;
    bit stalled, fa, fy;
    got_n = 0; stall_err = 0; stall_cnt = 0; timeout = 1'b0;
    while (got_n < n && cn < 2000) begin
      y_ready = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      a_valid = (idx < n);
      a_data  = (idx < n) ? pack_a(idx) : '0;
      a_last  = (idx == n - 1);
      w_valid = w_noise;
      w_data  = '1;
      #1;
      fa = a_valid && a_ready;
      fy = y_valid && y_ready;
      if (fy) begin
        got_y[got_n]    = y_data;
        got_last[got_n] = y_last;
        got_n++;
      end
      stalled = y_valid && !y_ready;
      held    = y_data;
      cyc();
      if (stalled) begin
        stall_cnt++;
        if (y_data !== held || y_valid !== 1'b1) stall_err++;
      end
      if (fa) idx++;
      cn++;
    end
    a_valid = 1'b0; a_last = 1'b0; a_data = '0; y_ready = 1'b1; w_valid = 1'b0; w_data = '0;
    stream_cycles = cn;
    if (got_n < n) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc();
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL reset_w_ready got=%b exp=1", w_ready); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
    checks++; if (y_last !== 1'b0) begin failures++; $display("FAIL reset_y_last got=%b exp=0", y_last); end
    checks++; if (y_data !== '0) begin failures++; $display("FAIL reset_y_data got=%h exp=0", y_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_identity();
    int k, lat;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = (r == c) ? 1 : 0;
    load_w();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ident_busy_compute got=%b exp=1", busy); end
    avec[0] = '{1, 2, 3, 4};
    y_ready = 1'b1;
    a_valid = 1'b1; a_data = pack_a(0); a_last = 1'b1;
    #1;
    k = 0;
    while (!a_ready && k < 10) begin cyc(); k++; end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL ident_a_ready got=%b exp=1", a_ready); end
    cyc();
    a_valid = 1'b0; a_last = 1'b0; a_data = '0;
    lat = 1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL ident_drain_a_ready got=%b exp=0", a_ready); end
    while (!y_valid && lat < 40) begin cyc(); lat++; end
    checks++; if (lat !== L) begin failures++; $display("FAIL ident_latency got=%0d exp=%0d", lat, L); end
    checks++; if (y_data !== {18'd4, 18'd3, 18'd2, 18'd1}) begin failures++; $display("FAIL ident_y_data got=%h exp=%h", y_data, {18'd4, 18'd3, 18'd2, 18'd1}); end
    checks++; if (y_last !== 1'b1) begin failures++; $display("FAIL ident_y_last got=%b exp=1", y_last); end
    cyc();
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL ident_back_to_load got=%b exp=1", w_ready); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL ident_y_valid_after got=%b exp=0", y_valid); end
  endtask

  task automatic test_signed();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = -128;
    load_w();
    avec[0] = '{-128, -128, -128, -128};
    run_stream(1, 1'b0);
    checks++; if (timeout) begin failures++; $display("FAIL signed_min_timeout got=%0d exp=1 results", got_n); end
    checks++; if (got_y[0] !== {4{18'd65536}}) begin failures++; $display("FAIL signed_min got=%h exp=%h", got_y[0], {4{18'd65536}}); end
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = 1;
    load_w();
    avec[0] = '{127, -128, 0, 1};
    run_stream(1, 1'b0);
    checks++; if (got_n !== 1 || got_y[0] !== '0) begin failures++; $display("FAIL signed_cancel got=%h n=%0d exp=0 n=1", got_y[0], got_n); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = r * 4 + c - 7;
    for (int i = 0; i < 10; i++) for (int r = 0; r < R; r++) avec[i][r] = ((i * 13 + r * 29 + 5) % 256) - 128;
    load_w();
    run_stream(10, 1'b1);
    checks++; if (got_n !== 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got_n); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_y[i] !== model_y(i) || got_last[i] !== (i == 9)) begin
        failures++; bad++;
        $display("FAIL bp_vec%0d got=%h last=%b exp=%h last=%b", i, got_y[i], got_last[i], model_y(i), (i == 9));
      end
    end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0 changes", stall_err); end
    checks++; if (stall_cnt == 0) begin failures++; $display("FAIL bp_stall_seen got=%0d exp=>0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) for (int r = 0; r < R; r++) avec[i][r] = (i + 1) * (r - 1);
    load_w();
    run_stream(6, 1'b0);
    checks++; if (stream_cycles !== 6 + L) begin failures++; $display("FAIL b2b_cycles got=%0d exp=%0d", stream_cycles, 6 + L); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_y[i] !== model_y(i)) begin failures++; $display("FAIL b2b_vec%0d got=%h exp=%h", i, got_y[i], model_y(i)); end
    end
  endtask

  task automatic test_reload();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = r + c + 1;
    load_w();
    checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL reload_w_ready_compute got=%b exp=0", w_ready); end
    avec[0] = '{3, -1, 2, 5};
    avec[1] = '{-7, 4, 0, 9};
    w_noise = 1'b1;
    run_stream(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_y[i] !== model_y(i)) begin failures++; $display("FAIL reload_b1_vec%0d got=%h exp=%h", i, got_y[i], model_y(i)); end
    end
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = (r == c) ? -2 : c - r;
    load_w();
    run_stream(2, 1'b0);
    w_noise = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_y[i] !== model_y(i)) begin failures++; $display("FAIL reload_b2_vec%0d got=%h exp=%h", i, got_y[i], model_y(i)); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wmat[r][c] = (r == c) ? 1 : 0;
    load_w();
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_last = 1'b0; a_data = {8'd9, 8'd8, 8'd7, 8'(i + 1)};
      cyc();
    end
    a_valid = 1'b0; a_data = '0;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rstmid_y_valid got=%b exp=0", y_valid); end
    checks++; if (w_ready !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL rstmid_state got=w%b a%b exp=w1 a0", w_ready, a_ready); end
    checks++; if (busy !== 1'b0 || y_data !== '0) begin failures++; $display("FAIL rstmid_clear got=busy%b y=%h exp=busy0 y=0", busy, y_data); end
    cyc();
    reset = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      cyc();
      if (y_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_output got=%0d exp=0", seen); end
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL rstmid_load_state got=%b exp=1", w_ready); end
  endtask

  task automatic test_wrap();
    int k;
    y8_ready = 1'b1;
    for (int r = 0; r < R; r++) begin
      w8_valid = 1'b1; w8_data = {4{8'd127}};
      cyc();
    end
    w8_valid = 1'b0;
    a8_valid = 1'b1; a8_last = 1'b1; a8_data = {4{8'd127}};
    #1;
    k = 0;
    while (!a8_ready && k < 10) begin cyc(); k++; end
    cyc();
    a8_valid = 1'b0; a8_last = 1'b0; a8_data = '0;
    k = 0;
    while (!y8_valid && k < 40) begin cyc(); k++; end
    checks++; if (y8_valid !== 1'b1) begin failures++; $display("FAIL wrap_timeout got=%b exp=1", y8_valid); end
    checks++; if (y8_data !== {4{8'd4}}) begin failures++; $display("FAIL wrap_value got=%h exp=%h", y8_data, {4{8'd4}}); end
    cyc();
  endtask

  initial begin
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_last = 1'b0; y_ready = 1'b1;
    w8_valid = 1'b0; w8_data = '0; a8_valid = 1'b0; a8_data = '0; a8_last = 1'b0; y8_ready = 1'b1;
    w_noise = 1'b0;
    reset = 1'b0;
    test_reset();
    test_identity();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reload();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
